// File: rtl/fetch_stage_if.sv
// Fetch-stage signal bundle: instruction-memory port plus the IF/ID register towards decode.
// imem handshake: imem_rd is a one-cycle request for imem_addr; the word is taken on the
// first cycle imem_done=1 (possibly the request cycle itself); imem_stall=1 forbids a request.
interface fetch_stage_if;
    logic [15:0] imem_addr;
    logic        imem_rd;
    logic [15:0] imem_data;
    logic        imem_done;
    logic        imem_stall;
    logic        stall_in;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halt;
    logic [15:0] instruct;
    logic [15:0] pc_plus2;
    logic        inst_valid;
    logic        err;

    modport master (
        output imem_addr, imem_rd, instruct, pc_plus2, inst_valid, err,
        input  imem_data, imem_done, imem_stall, stall_in, redirect, redirect_pc, halt
    );

    modport slave (
        input  imem_addr, imem_rd, instruct, pc_plus2, inst_valid, err,
        output imem_data, imem_done, imem_stall, stall_in, redirect, redirect_pc, halt
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch with IF/ID register: PC, multi-cycle imem reads, one-entry skid,
// redirect with squash of an in-flight read, halt and sticky misalignment error.
module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic                clk,
    input  logic                rst,
    fetch_stage_if.master       bus,
    output logic [2:0]          state_dbg
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_WAIT   = 3'd1,
        S_HOLD   = 3'd2,
        S_HALTED = 3'd3,
        S_ERR    = 3'd4
    } state_t;

    state_t      state;
    logic [15:0] pc;
    logic [15:0] pc_next;
    logic [15:0] target;
    logic [15:0] skid_instr;
    logic        skid_valid;
    logic        squash;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc2;
    logic        ifid_valid;
    logic        err_q;
    logic        fetch_go;

    assign pc_next  = pc + 16'd2;
    assign fetch_go = (state == S_FETCH) && !pc[0] && !rst && !bus.stall_in &&
                      !bus.imem_stall && !bus.redirect && !bus.halt;

    assign bus.imem_addr  = pc;
    assign bus.imem_rd    = fetch_go;
    assign bus.instruct   = ifid_instr;
    assign bus.pc_plus2   = ifid_pc2;
    assign bus.inst_valid = ifid_valid;
    assign bus.err        = err_q;
    assign state_dbg      = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_FETCH;
            pc         <= RESET_PC;
            target     <= RESET_PC;
            skid_instr <= NOP_INSTR;
            skid_valid <= 1'b0;
            squash     <= 1'b0;
            ifid_instr <= NOP_INSTR;
            ifid_pc2   <= 16'h0000;
            ifid_valid <= 1'b0;
            err_q      <= 1'b0;
        end else if (state != S_HALTED && state != S_ERR) begin
            if (bus.redirect) begin
                ifid_instr <= NOP_INSTR;
                ifid_pc2   <= 16'h0000;
                ifid_valid <= 1'b0;
                skid_valid <= 1'b0;
                if (bus.redirect_pc[0]) begin
                    err_q  <= 1'b1;
                    squash <= 1'b0;
                    state  <= S_ERR;
                end else if (state == S_WAIT && !bus.imem_done) begin
                    // Keep the address stable for the read in flight; jump once it completes.
                    squash <= 1'b1;
                    target <= bus.redirect_pc;
                end else begin
                    pc     <= bus.redirect_pc;
                    squash <= 1'b0;
                    state  <= S_FETCH;
                end
            end else if (bus.halt) begin
                state <= S_HALTED;
            end else begin
                case (state)
                    S_FETCH: begin
                        if (pc[0]) begin
                            err_q      <= 1'b1;
                            state      <= S_ERR;
                            ifid_instr <= NOP_INSTR;
                            ifid_pc2   <= 16'h0000;
                            ifid_valid <= 1'b0;
                        end else if (fetch_go && bus.imem_done) begin
                            ifid_instr <= bus.imem_data;
                            ifid_pc2   <= pc_next;
                            ifid_valid <= 1'b1;
                            pc         <= pc_next;
                        end else if (!bus.stall_in) begin
                            // Decode is consuming: present a bubble rather than repeat.
                            ifid_instr <= NOP_INSTR;
                            ifid_pc2   <= 16'h0000;
                            ifid_valid <= 1'b0;
                            if (fetch_go) state <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (bus.imem_done && squash) begin
                            pc     <= target;
                            squash <= 1'b0;
                            state  <= S_FETCH;
                        end else if (bus.imem_done && !bus.stall_in) begin
                            ifid_instr <= bus.imem_data;
                            ifid_pc2   <= pc_next;
                            ifid_valid <= 1'b1;
                            pc         <= pc_next;
                            state      <= S_FETCH;
                        end else if (bus.imem_done) begin
                            skid_instr <= bus.imem_data;
                            skid_valid <= 1'b1;
                            pc         <= pc_next;
                            state      <= S_HOLD;
                        end
                        if (!bus.stall_in && !(bus.imem_done && !squash)) begin
                            ifid_instr <= NOP_INSTR;
                            ifid_pc2   <= 16'h0000;
                            ifid_valid <= 1'b0;
                        end
                    end
                    S_HOLD: begin
                        if (!bus.stall_in) begin
                            // pc already advanced past the skid word, so it is that word's PC+2.
                            ifid_instr <= skid_valid ? skid_instr : NOP_INSTR;
                            ifid_pc2   <= skid_valid ? pc : 16'h0000;
                            ifid_valid <= skid_valid;
                            skid_valid <= 1'b0;
                            state      <= S_FETCH;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
